// File: rtl/instr_loader_if.sv
// Stream-in and instruction-memory-write bundle for the boot-time program loader.
interface instr_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_w_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_w_data;
  logic       cpu_hold;
  logic       cpu_start;
  logic       loaded;
  logic       err;

  // Source side: feeds the byte stream and observes the loader.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_w_en, mem_addr, mem_w_data,
           cpu_hold, cpu_start, loaded, err
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_w_en, mem_addr, mem_w_data,
           cpu_hold, cpu_start, loaded, err
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: receives a framed byte stream (SYNC, LEN, data,
// CSUM), writes the data into instruction memory from address 0, appends a
// stop instruction and releases the CPU once the checksum matches.
module instr_loader (
  input  logic           clk,
  input  logic           reset,
  instr_loader_if.slave  bus
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] TERM_WORD = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_TERM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state, state_nxt;

  // Control / registered outputs
  logic       w_en_q,   w_en_nxt;
  logic [7:0] addr_q,   addr_nxt;
  logic [7:0] wdata_q,  wdata_nxt;
  logic       hold_q,   hold_nxt;
  logic       start_q,  start_nxt;
  logic       loaded_q, loaded_nxt;
  logic       err_q,    err_nxt;

  // Frame bookkeeping (fully reloaded on every LEN byte, so left unreset)
  logic [7:0] count_q, count_nxt;
  logic [7:0] idx_q,   idx_nxt;
  logic [7:0] sum_q,   sum_nxt;

  logic       xfer;
  logic       is_sync;
  logic       csum_ok;

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign bus.in_ready = !reset && (state != S_TERM);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign is_sync      = (bus.in_data == SYNC_BYTE);
  assign csum_ok      = (bus.in_data == sum_q);

  // Next-state decode of the frame parser.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (xfer && is_sync) state_nxt = S_LEN;
      S_LEN:   if (xfer) state_nxt = (bus.in_data == 8'd0) ? S_IDLE : S_DATA;
      S_DATA:  if (xfer && (idx_q == count_q - 8'd1)) state_nxt = S_CSUM;
      S_CSUM:  if (xfer) state_nxt = csum_ok ? S_TERM : S_IDLE;
      S_TERM:  state_nxt = S_DONE;
      S_DONE:  if (xfer && is_sync) state_nxt = S_LEN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and frame counters.
  always_comb begin
    w_en_nxt   = 1'b0;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    hold_nxt   = hold_q;
    start_nxt  = 1'b0;
    loaded_nxt = loaded_q;
    err_nxt    = err_q;
    count_nxt  = count_q;
    idx_nxt    = idx_q;
    sum_nxt    = sum_q;
    unique case (state)
      S_IDLE, S_DONE: begin
        // A sync byte (re)starts a load: the CPU is parked before any write.
        if (xfer && is_sync) begin
          hold_nxt   = 1'b1;
          loaded_nxt = 1'b0;
          err_nxt    = 1'b0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (bus.in_data == 8'd0) begin
            err_nxt = 1'b1;
          end else begin
            count_nxt = bus.in_data;
            idx_nxt   = 8'd0;
            sum_nxt   = 8'd0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          w_en_nxt  = 1'b1;
          addr_nxt  = idx_q;
          wdata_nxt = bus.in_data;
          sum_nxt   = csum_add(sum_q, bus.in_data);
          idx_nxt   = idx_q + 8'd1;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (csum_ok) begin
            // Terminator lands one cycle before the CPU is released.
            w_en_nxt  = 1'b1;
            addr_nxt  = count_q;
            wdata_nxt = TERM_WORD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_TERM: begin
        start_nxt  = 1'b1;
        hold_nxt   = 1'b0;
        loaded_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // State and control registers; reset wins over any simultaneous transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      w_en_q   <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      hold_q   <= 1'b1;
      start_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      w_en_q   <= w_en_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      hold_q   <= hold_nxt;
      start_q  <= start_nxt;
      loaded_q <= loaded_nxt;
      err_q    <= err_nxt;
    end
  end

  // Frame counters: length, write index and running checksum.
  always_ff @(posedge clk) begin
    count_q <= count_nxt;
    idx_q   <= idx_nxt;
    sum_q   <= sum_nxt;
  end

  assign bus.mem_w_en   = w_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_w_data = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.cpu_start  = start_q;
  assign bus.loaded     = loaded_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader: frames are driven byte by byte and the
// memory writes / start pulses are logged for comparison against hand values.
module tb_instr_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  instr_loader_if bus ();

  instr_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  logic       wr_hold_q[$];
  int         st_cyc_q[$];
  logic [7:0] frame_q[$];

  // Log every memory write and start pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_w_en === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_w_data);
      wr_cyc_q.push_back(cyc);
      wr_hold_q.push_back(bus.cpu_hold);
    end
    if (bus.cpu_start === 1'b1) st_cyc_q.push_back(cyc);
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    wr_hold_q.delete();
    st_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte_ready: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({bus.mem_w_en, bus.mem_addr, bus.mem_w_data, bus.cpu_hold, bus.cpu_start, bus.loaded, bus.err}
        !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: w_en=%b addr=%h data=%h hold=%b start=%b loaded=%b err=%b required 0,00,00,1,0,0,0",
               bus.mem_w_en, bus.mem_addr, bus.mem_w_data, bus.cpu_hold, bus.cpu_start, bus.loaded, bus.err);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b required 0", bus.in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: in_ready=%b required 1", bus.in_ready);
    end
    clear_log();
  endtask

  task automatic test_good_frame();
    logic [7:0] ea[3];
    logic [7:0] ed[3];
    ea = '{8'h00, 8'h01, 8'h02};
    ed = '{8'h12, 8'h34, 8'h00};
    clear_log();
    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h46};
    send_frame();
    idle(4);
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL good_write_count: got %0d required 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {ea[i], ed[i]}) begin
          errors++;
          $display("FAIL good_write_%0d: got (%h,%h) required (%h,%h)", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
        end
      end
      checks++;
      if (wr_cyc_q[1] != wr_cyc_q[0] + 1 || wr_cyc_q[2] != wr_cyc_q[1] + 1) begin
        errors++;
        $display("FAIL good_write_timing: cycles %0d,%0d,%0d required consecutive", wr_cyc_q[0], wr_cyc_q[1], wr_cyc_q[2]);
      end
      checks++;
      if (wr_hold_q[2] !== 1'b1) begin
        errors++;
        $display("FAIL good_term_hold: cpu_hold=%b during terminator write required 1", wr_hold_q[2]);
      end
      checks++;
      if (st_cyc_q.size() != 1) begin
        errors++;
        $display("FAIL good_start_count: got %0d required 1", st_cyc_q.size());
      end else begin
        checks++;
        if (st_cyc_q[0] != wr_cyc_q[2] + 1) begin
          errors++;
          $display("FAIL good_start_timing: start cycle %0d required %0d", st_cyc_q[0], wr_cyc_q[2] + 1);
        end
      end
    end
    checks++;
    if ({bus.loaded, bus.cpu_hold, bus.err} !== 3'b100) begin
      errors++;
      $display("FAIL good_status: loaded,hold,err=%b%b%b required 100", bus.loaded, bus.cpu_hold, bus.err);
    end
  endtask

  task automatic test_bad_csum();
    clear_log();
    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h47};
    send_frame();
    idle(4);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL bad_write_count: got %0d required 2", wr_addr_q.size());
    end else begin
      checks++;
      if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== {8'h00, 8'h12, 8'h01, 8'h34}) begin
        errors++;
        $display("FAIL bad_writes: got (%h,%h),(%h,%h) required (00,12),(01,34)",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if (st_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL bad_no_start: got %0d pulses required 0", st_cyc_q.size());
    end
    checks++;
    if ({bus.err, bus.loaded, bus.cpu_hold, bus.in_ready} !== 4'b1011) begin
      errors++;
      $display("FAIL bad_status: err,loaded,hold,ready=%b%b%b%b required 1011",
               bus.err, bus.loaded, bus.cpu_hold, bus.in_ready);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    frame_q = '{8'hA5, 8'h00};
    send_frame();
    idle(3);
    checks++;
    if (wr_addr_q.size() != 0 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL zero_len: writes=%0d err=%b required 0 writes err=1", wr_addr_q.size(), bus.err);
    end
    clear_log();
    send_byte(8'hA5);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_err_clear: err=%b required 0", bus.err);
    end
    frame_q = '{8'h01, 8'h33, 8'h33};
    send_frame();
    idle(4);
    checks++;
    if (wr_addr_q.size() != 2 || st_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL zero_len_reload_count: writes=%0d starts=%0d required 2 and 1", wr_addr_q.size(), st_cyc_q.size());
    end else begin
      checks++;
      if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== {8'h00, 8'h33, 8'h01, 8'h00}) begin
        errors++;
        $display("FAIL zero_len_reload_writes: got (%h,%h),(%h,%h) required (00,33),(01,00)",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if ({bus.loaded, bus.err, bus.cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL zero_len_reload_status: loaded,err,hold=%b%b%b required 100", bus.loaded, bus.err, bus.cpu_hold);
    end
  endtask

  task automatic test_garbage_sync_data();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_log();
    frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5, 8'hA5};
    send_frame();
    idle(4);
    checks++;
    if (wr_addr_q.size() != 2 || st_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL garbage_count: writes=%0d starts=%0d required 2 and 1", wr_addr_q.size(), st_cyc_q.size());
    end else begin
      checks++;
      if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== {8'h00, 8'hA5, 8'h01, 8'h00}) begin
        errors++;
        $display("FAIL garbage_writes: got (%h,%h),(%h,%h) required (00,A5),(01,00)",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if ({bus.loaded, bus.cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL garbage_status: loaded,hold=%b%b required 10", bus.loaded, bus.cpu_hold);
    end
  endtask

  task automatic test_reload();
    clear_log();
    send_byte(8'hA5);
    checks++;
    if ({bus.cpu_hold, bus.loaded} !== 2'b10) begin
      errors++;
      $display("FAIL reload_sync_edge: hold,loaded=%b%b required 10", bus.cpu_hold, bus.loaded);
    end
    frame_q = '{8'h01, 8'h07, 8'h07};
    send_frame();
    idle(4);
    checks++;
    if (wr_addr_q.size() != 2 || st_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL reload_count: writes=%0d starts=%0d required 2 and 1", wr_addr_q.size(), st_cyc_q.size());
    end else begin
      checks++;
      if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== {8'h00, 8'h07, 8'h01, 8'h00}) begin
        errors++;
        $display("FAIL reload_writes: got (%h,%h),(%h,%h) required (00,07),(01,00)",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if ({bus.loaded, bus.cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL reload_status: loaded,hold=%b%b required 10", bus.loaded, bus.cpu_hold);
    end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    frame_q = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03};
    foreach (frame_q[i]) send_byte(frame_q[i]);
    bus.in_data = 8'h04;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midframe_ready: in_ready=%b during reset required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_w_en, bus.mem_addr, bus.mem_w_data, bus.cpu_hold, bus.cpu_start, bus.loaded, bus.err, bus.in_ready}
        !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset_values: w_en=%b addr=%h data=%h hold=%b start=%b loaded=%b err=%b ready=%b required 0,00,00,1,0,0,0,0",
               bus.mem_w_en, bus.mem_addr, bus.mem_w_data, bus.cpu_hold, bus.cpu_start, bus.loaded, bus.err, bus.in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL midframe_partial_writes: got %0d required 3", wr_addr_q.size());
    end
    clear_log();
    frame_q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h65};
    send_frame();
    idle(4);
    checks++;
    if (wr_addr_q.size() != 3 || st_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL midframe_fresh_count: writes=%0d starts=%0d required 3 and 1", wr_addr_q.size(), st_cyc_q.size());
    end else begin
      checks++;
      if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], wr_addr_q[2], wr_data_q[2]}
          !== {8'h00, 8'hAA, 8'h01, 8'hBB, 8'h02, 8'h00}) begin
        errors++;
        $display("FAIL midframe_fresh_writes: got (%h,%h),(%h,%h),(%h,%h) required (00,AA),(01,BB),(02,00)",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], wr_addr_q[2], wr_data_q[2]);
      end
    end
    checks++;
    if ({bus.loaded, bus.cpu_hold, bus.err} !== 3'b100) begin
      errors++;
      $display("FAIL midframe_fresh_status: loaded,hold,err=%b%b%b required 100", bus.loaded, bus.cpu_hold, bus.err);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len();
    test_garbage_sync_data();
    test_reload();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader: the write side of the CPU's instruction memory. Accepts a framed byte stream over a valid/ready handshake, writes the instruction bytes into instruction memory starting at address 0, verifies an 8-bit checksum, and writes a 0x00 terminator. It holds the CPU in reset until the image is valid, then releases it with a one-cycle start pulse.

## Interface
- SYNC_BYTE, 8'hA5: frame start marker.
- TERM_WORD, 8'h00: word written after the last instruction. It is the CPU's stop instruction.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte. A byte transfers on an edge where in_valid && in_ready.
- mem_w_en  out  1  instruction-memory write strobe, one cycle per write.
- mem_addr  out  8  write address.
- mem_w_data  out  8  write data.
- cpu_hold  out  1  CPU held (no fetch) while 1.
- cpu_start  out  1  one-cycle pulse when the image is committed.
- loaded  out  1  a valid image is resident.
- err  out  1  last frame was rejected (bad length or checksum).

## Operation
- Frame format: SYNC_BYTE, LEN (1..255), LEN instruction bytes, CSUM.
- CSUM must equal the sum of the instruction bytes mod 256.
- States: IDLE, LEN, DATA, CSUM, TERM, DONE.
- IDLE
  - Accepts every byte. Non-sync bytes are dropped.
  - SYNC_BYTE → LEN; clears err; sets cpu_hold=1, loaded=0.
- LEN
  - 0 → IDLE with err=1.
  - Otherwise latch count N, clear index and running sum → DATA.
- DATA
  - Each accepted byte is written to mem_addr=index and added to the sum; index increments.
  - After byte N-1 → CSUM.
  - SYNC_BYTE is treated as data here; there is no resync inside a frame.
- CSUM
  - Match → TERM, and issue a write of TERM_WORD at address N.
  - Mismatch → IDLE with err=1. No terminator is written; cpu_hold stays 1.
- TERM: one cycle → DONE. Sets cpu_start=1 (one cycle), cpu_hold=0, loaded=1.
- DONE
  - Accepts bytes. Non-sync bytes are dropped.
  - SYNC_BYTE starts a reload: → LEN, cpu_hold=1, loaded=0, err=0.
- Index and sum are 8 bits wide. N≤255, so the terminator address N never wraps.
- Memory bytes already written before an abort or reset are not erased. A failed frame leaves a partial image in memory, but cpu_hold keeps the CPU from running it.

## Timing
- Reset values: state=IDLE, mem_w_en=0, mem_addr=0, mem_w_data=0, cpu_hold=1, cpu_start=0, loaded=0, err=0.
- in_ready
  - Combinational: 0 while reset=1 or state=TERM; 1 in every other state.
  - The first transfer is possible on the first edge after reset deasserts.
- All other outputs are registered.
- A data byte accepted at edge k gives mem_w_en=1 with its address and data during cycle k..k+1 only. Back-to-back bytes produce back-to-back writes.
- CSUM accepted at edge k:
  - Terminator write is visible from edge k (state TERM).
  - cpu_start/cpu_hold=0/loaded visible from edge k+1.
  - The terminator write always completes before the CPU is released.
- in_valid low in any state: the loader holds its state. No timeout.
- Reset asserted mid-frame: returns to reset values on that edge. A pending mem_w_en is dropped next cycle.
- Reset beats any simultaneous transfer on the same edge.

## Test plan
- Frame A5,02,12,34,46:
  - writes (0,12), (1,34), (2,00) on consecutive cycles.
  - cpu_start pulses exactly once, one cycle after the (2,00) write.
  - After that: loaded=1, cpu_hold=0, err=0.
- Frame A5,02,12,34,47 (bad CSUM):
  - writes (0,12), (1,34) only.
  - err=1, loaded=0, cpu_hold=1, no cpu_start, state IDLE.
- Frame A5,00 → err=1, no writes. A following good frame clears err and loads normally.
- Garbage 00,FF,5A before A5,01,A5,A5:
  - garbage is dropped.
  - A5 inside DATA is written as (0,A5), then terminator (1,00), then start.
- Good load, then A5,01,07,07 from DONE:
  - cpu_hold rises on the sync acceptance edge; loaded drops.
  - writes (0,07), (1,00), then a second cpu_start.
- reset pulsed after 3 of 5 data bytes, with in_valid held high throughout:
  - all outputs return to reset values.
  - in_ready=0 during reset.
  - a fresh frame afterwards loads correctly from address 0.
